// File: rtl/piso_shift_register_param_if.sv
// ---------------------------------------------------------------------------
// piso_shift_register_param_if
//   Bundles the word-load handshake and the serial link of the parametrised
//   PISO shift register.
//
//   Signals:
//     load_valid   producer -> PISO  a word is waiting on parallel_in
//     load_ready   PISO -> producer  the word is taken this cycle
//     parallel_in  producer -> PISO  WIDTH-bit word to serialise
//     shift_en     link -> PISO      advance one bit this cycle
//     serial_out   PISO -> link      current serial bit
//     serial_valid PISO -> link      serial_out carries a data bit
//     serial_last  PISO -> link      serial_out is the final bit of the word
//     bits_left    PISO -> link      bits still to send after the current one
//
//   Modports: master = producer/link side, slave = PISO side.
// ---------------------------------------------------------------------------
interface piso_shift_register_param_if #(
  parameter int WIDTH = 8
);
  localparam int BW = $clog2(WIDTH);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] parallel_in;
  logic             shift_en;
  logic             serial_out;
  logic             serial_valid;
  logic             serial_last;
  logic [BW-1:0]    bits_left;

  modport master (
    output load_valid, parallel_in, shift_en,
    input  load_ready, serial_out, serial_valid, serial_last, bits_left
  );

  modport slave (
    input  load_valid, parallel_in, shift_en,
    output load_ready, serial_out, serial_valid, serial_last, bits_left
  );
endinterface

// File: rtl/piso_shift_register_param.sv
// ---------------------------------------------------------------------------
// piso_shift_register_param
//   Parallel-in / serial-out shift register with generic width, selectable
//   bit order, a valid/ready load handshake, a shift-enable stall, a
//   remaining-bit counter and first/last framing. Words stream back to back
//   with no idle gap: a new word can be accepted on the edge that retires
//   the final bit of the previous one.
//
//   Parameters:
//     WIDTH      word width in bits (>= 2)
//     MSB_FIRST  1 = bit WIDTH-1 goes out first, 0 = bit 0 goes out first
//
//   Ports:
//     clk      system clock, rising edge
//     rst_n    asynchronous active-low reset
//     io_link  slave side of piso_shift_register_param_if
// ---------------------------------------------------------------------------
module piso_shift_register_param #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  piso_shift_register_param_if.slave    io_link
);

  localparam int            BW       = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);
  localparam logic [BW-1:0] ONE_LEFT = BW'(1);

  // Remaining bits of the word in transmit order; the next bit to go out
  // sits in the top position so every shift is a plain left shift.
  logic [WIDTH-2:0] r_shift;
  logic             r_serialOut;
  logic             r_serialValid;
  logic             r_serialLast;
  logic [BW-1:0]    r_bitsLeft;

  logic             w_loadReady;
  logic             w_accept;
  logic             w_firstBit;
  logic [WIDTH-2:0] w_loadShift;

  // Ready while idle, or while the final bit is being retired this cycle,
  // which is what lets consecutive words stream without a gap.
  assign w_loadReady = !r_serialValid || (io_link.shift_en && (r_bitsLeft == '0));
  assign w_accept    = io_link.load_valid && w_loadReady;

  // Split the incoming word into the first bit and the rest, reordered so
  // the rest always leaves the register from the top regardless of order.
  always_comb begin
    w_firstBit  = MSB_FIRST ? io_link.parallel_in[WIDTH-1] : io_link.parallel_in[0];
    w_loadShift = '0;
    for (int k = 0; k < WIDTH - 1; k++) begin
      if (MSB_FIRST)
        w_loadShift[WIDTH-2-k] = io_link.parallel_in[WIDTH-2-k];
      else
        w_loadShift[WIDTH-2-k] = io_link.parallel_in[1+k];
    end
  end

  // Serialiser state. A load takes priority because it can only coincide
  // with the word-end edge; otherwise a shift-enabled busy edge either
  // advances one bit or, on the final bit, drops back to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift       <= '0;
      r_serialOut   <= 1'b0;
      r_serialValid <= 1'b0;
      r_serialLast  <= 1'b0;
      r_bitsLeft    <= '0;
    end else if (w_accept) begin
      r_shift       <= w_loadShift;
      r_serialOut   <= w_firstBit;
      r_serialValid <= 1'b1;
      r_serialLast  <= 1'b0;
      r_bitsLeft    <= LAST_IDX;
    end else if (r_serialValid && io_link.shift_en) begin
      if (r_bitsLeft != '0) begin
        r_serialOut  <= r_shift[WIDTH-2];
        r_shift      <= r_shift << 1;
        r_bitsLeft   <= r_bitsLeft - 1'b1;
        r_serialLast <= (r_bitsLeft == ONE_LEFT);
      end else begin
        r_serialOut   <= 1'b0;
        r_serialValid <= 1'b0;
        r_serialLast  <= 1'b0;
      end
    end
  end

  assign io_link.load_ready   = w_loadReady;
  assign io_link.serial_out   = r_serialOut;
  assign io_link.serial_valid = r_serialValid;
  assign io_link.serial_last  = r_serialLast;
  assign io_link.bits_left    = r_bitsLeft;

endmodule

// File: doc/piso_shift_register_param.md
Name: piso_shift_register_param

Overview:
- Parametrised parallel-in/serial-out shift register. It is the next generation of the 4-bit PISO.
- It adds generic width, selectable bit order, a valid/ready load handshake, a shift-enable stall, a bit counter, and framing outputs.
- It sits between a word-wide producer and a 1-bit serial link. Back-to-back words stream with no idle gap.

Parameters:
- WIDTH, 8, word width in bits (>= 2).
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  producer has a word on parallel_in.
- load_ready  output  1  block accepts a word this cycle (combinational).
- parallel_in  input  WIDTH  word to serialise; sampled only on an accepted load.
- shift_en  input  1  1 = advance one bit this cycle; 0 = hold the current bit.
- serial_out  output  1  current serial bit (registered).
- serial_valid  output  1  serial_out carries a valid data bit (registered).
- serial_last  output  1  serial_out is the final bit of the word (registered).
- bits_left  output  $clog2(WIDTH)  bits still to be sent after the current one (registered).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0, all state clears immediately:
  - shift register = 0, serial_out = 0, serial_valid = 0, serial_last = 0, bits_left = 0.
  - load_ready = 1 whenever rst_n = 1 and idle.
- Accept condition: accept = load_valid && load_ready.
- load_ready = !serial_valid || (shift_en && bits_left == 0). An accept can therefore coincide with the final bit being shifted out.
- Load on an accepted edge:
  - serial_out <= first bit: parallel_in[WIDTH-1] if MSB_FIRST, else parallel_in[0].
  - The remaining WIDTH-1 bits go into the shift register in transmit order.
  - bits_left <= WIDTH-1, serial_valid <= 1, serial_last <= 0.
  - Latency: the first bit is valid on the cycle after the accepting edge.
- Shift on an edge with serial_valid=1, shift_en=1 and bits_left > 0:
  - serial_out <= next bit; the shift register moves one position toward the output and zero-fills.
  - bits_left decrements.
  - serial_last <= (bits_left == 1).
- Word end on an edge with serial_valid=1, shift_en=1 and bits_left == 0:
  - With an accept on the same edge: load the new word as above (seamless stream).
  - Without an accept: serial_valid <= 0, serial_last <= 0, serial_out <= 0.
- Stall: with shift_en=0, serial_out, serial_last, bits_left and the shift register all hold. No accept is possible while serial_valid=1.
- Idle: when serial_valid=0, shift_en is ignored and outputs hold their reset/idle values.
- Sizing: each word yields exactly WIDTH valid bits over WIDTH shift_en-qualified cycles. serial_last is high on exactly one of them, the last.
- load_valid while busy: the word is not taken, and parallel_in is not sampled. The producer must hold load_valid and parallel_in until accepted.
- Reset mid-word: the word in flight is discarded and there is no partial-bit output. After release, the block is idle and ready.
- No combinational path from parallel_in to serial_out. The only combinational path is from shift_en / serial state to load_ready.
- States, implicit from serial_valid/bits_left:
  - IDLE (serial_valid=0) -> SHIFTING on accept.
  - SHIFTING -> SHIFTING on a bit advance or a back-to-back accept.
  - SHIFTING -> IDLE on a last bit with no accept.

Test Plan (WIDTH=4 unless noted):
- Reset check: assert rst_n=0 mid-cycle with no clock edge -> all outputs 0 immediately. Release -> load_ready=1, serial_valid=0.
- MSB_FIRST=1, load 4'b1101, shift_en=1 constant -> serial_out 1,1,0,1 on 4 consecutive cycles. serial_last high only on the 4th. bits_left 3,2,1,0. serial_valid falls on the 5th cycle.
- MSB_FIRST=0, load 4'b1101 -> serial_out 1,0,1,1.
- Back-to-back: 4'b1010 then 4'b0110 with load_valid held high -> load_ready=1 only on the idle cycle and on the last-bit cycle. Serial stream is 1,0,1,0,0,1,1,0 with no gap. serial_last pulses after bits 4 and 8.
- Stall: load 4'b1001, drop shift_en for 3 cycles after the 2nd bit -> serial_out holds 0 with bits_left=2 during the stall. The sequence resumes 0,1. Total valid cycles = 4 + 3.
- Reset mid-word and WIDTH=8: load 8'hA5, assert rst_n low after the 3rd bit -> outputs 0 at once. After release, load 8'h3C -> stream 0,0,1,1,1,1,0,0, then idle.
